// File: rtl/decode_pkg.sv
// Shared decode definitions: immediate mode encodings
// and the wide-move halfword shift unit.
package decode_pkg;

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_D    = 3'b001,
    IMM_B    = 3'b010,
    IMM_CB   = 3'b011,
    IMM_MOVZ = 3'b100,
    IMM_MOVK = 3'b101,
    IMM_MOVN = 3'b110,
    IMM_ILL  = 3'b111
  } imm_ctrl_e;

  localparam int HW_SHIFT_UNIT = 16;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extract/extend, branch shift and MOVK merge.
// In: imm, ctrl, brshift, src (MOVK base). Out: result, illegal.
module imm_extract
  import decode_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int IMM_W    = 26,
  parameter int BR_SHIFT = 2
) (
  input  logic [IMM_W-1:0]  imm,
  input  logic [2:0]        ctrl,
  input  logic              brshift,
  input  logic [DATA_W-1:0] src,
  output logic [DATA_W-1:0] result,
  output logic              illegal
);

  localparam int XW = DATA_W + BR_SHIFT;

  imm_ctrl_e       mode;
  logic [1:0]      hw;
  logic [15:0]     imm16;
  logic [6:0]      sh;
  logic            hw_bad;
  logic            br_sh;
  logic [XW-1:0]   wide;
  logic [XW-1:0]   mask;
  logic [XW-1:0]   x;
  logic            unused_hi;

  assign mode   = imm_ctrl_e'(ctrl);
  assign hw     = imm[22:21];
  assign imm16  = imm[20:5];
  assign sh     = 7'(hw) * 7'(HW_SHIFT_UNIT);
  assign hw_bad = sh >= 7'(DATA_W);
  assign wide   = XW'(imm16) << sh;
  assign mask   = XW'(16'hFFFF) << sh;
  assign br_sh  = brshift &&
                  (mode == IMM_B || mode == IMM_CB);

  always_comb begin
    x       = '0;
    illegal = 1'b0;
    unique case (1'b1)
      mode == IMM_I:  x = XW'(imm[21:10]);
      mode == IMM_D:  x = XW'($signed(imm[20:12]));
      mode == IMM_B:  x = XW'($signed(imm));
      mode == IMM_CB: x = XW'($signed(imm[23:5]));
      mode == IMM_MOVZ: begin
        x       = wide;
        illegal = hw_bad;
      end
      mode == IMM_MOVK: begin
        x       = (XW'(src) & ~mask) | wide;
        illegal = hw_bad;
      end
      mode == IMM_MOVN: begin
        x       = ~wide;
        illegal = hw_bad;
      end
      default: illegal = 1'b1;
    endcase
    if (br_sh) x = x << BR_SHIFT;
    if (illegal) x = '0;
  end

  // Extra headroom bits exist only to carry the branch shift.
  assign result    = x[DATA_W-1:0];
  assign unused_hi = ^x[XW-1:DATA_W];

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready handshake and a
// one-entry MOV constant accumulator. In: Imm26/Ctrl/BrShift/Rd/Base
// request; Out: OutBus qualified by Illegal and AccHit.
module imm_gen_pipe
  import decode_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int IMM_W    = 26,
  parameter int BR_SHIFT = 2
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [IMM_W-1:0]  Imm26,
  input  logic [2:0]        Ctrl,
  input  logic              BrShift,
  input  logic [4:0]        Rd,
  input  logic [DATA_W-1:0] Base,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutBus,
  output logic              Illegal,
  output logic              AccHit
);

  imm_ctrl_e         ctrl_e;
  logic              take;
  logic              hit;
  logic              is_mov;
  logic              ill;
  logic              acc_valid;
  logic [4:0]        acc_tag;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] src;
  logic [DATA_W-1:0] res;

  assign ctrl_e  = imm_ctrl_e'(Ctrl);
  assign InReady = !OutValid || OutReady;
  assign take    = InValid && InReady && !Flush;
  assign is_mov  = ctrl_e == IMM_MOVZ ||
                   ctrl_e == IMM_MOVK ||
                   ctrl_e == IMM_MOVN;
  assign hit     = acc_valid && acc_tag == Rd &&
                   ctrl_e == IMM_MOVK;
  // A hit skips the stale register-file value of Rd.
  assign src     = hit ? acc_q : Base;

  imm_extract #(
    .DATA_W   (DATA_W),
    .IMM_W    (IMM_W),
    .BR_SHIFT (BR_SHIFT)
  ) u_ext (
    .imm     (Imm26),
    .ctrl    (Ctrl),
    .brshift (BrShift),
    .src     (src),
    .result  (res),
    .illegal (ill)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      OutValid  <= 1'b0;
      OutBus    <= '0;
      Illegal   <= 1'b0;
      AccHit    <= 1'b0;
      acc_valid <= 1'b0;
      acc_tag   <= '0;
      acc_q     <= '0;
    end else if (Flush) begin
      OutValid  <= 1'b0;
      Illegal   <= 1'b0;
      AccHit    <= 1'b0;
      acc_valid <= 1'b0;
    end else if (take) begin
      OutValid <= 1'b1;
      OutBus   <= res;
      Illegal  <= ill;
      AccHit   <= hit && !ill;
      if (is_mov && !ill) begin
        acc_valid <= 1'b1;
        acc_tag   <= Rd;
        acc_q     <= res;
      end
    end else if (OutReady) begin
      OutValid <= 1'b0;
    end
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, registered successor to the combinational immediate sign extender in the decode stage.
- Extracts and extends I, D, B and CB immediates to DATA_W bits, with optional pre-shifted branch offsets.
- Adds MOVZ, MOVN and MOVK wide-immediate modes. A one-entry constant accumulator lets a MOVZ/MOVK chain to the same Rd build its constant without a register-file read.
- Sits between instruction decode and the ID/EX register, with a valid/ready handshake on both sides.

Parameters:
- DATA_W, 64, output width; legal values are 32 and 64.
- IMM_W, 26, instruction immediate field width (Imm26).
- BR_SHIFT, 2, left shift applied to B/CB offsets when BrShift=1.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Flush  in  1  synchronous pipeline flush.
- InValid  in  1  request valid.
- InReady  out  1  request accepted when InValid && InReady.
- Imm26  in  IMM_W  instruction bits [25:0].
- Ctrl  in  3  mode select.
- BrShift  in  1  apply BR_SHIFT to B/CB results.
- Rd  in  5  destination register number (MOV modes only).
- Base  in  DATA_W  register-file value of Rd, used by MOVK on an accumulator miss.
- OutValid  out  1  result valid.
- OutReady  in  1  consumer ready.
- OutBus  out  DATA_W  extended immediate.
- Illegal  out  1  qualifies OutBus; the mode or halfword was illegal.
- AccHit  out  1  qualifies OutBus; MOVK merged into the accumulator rather than Base.

Behaviour:
- Reset (async): OutValid=0, OutBus=0, Illegal=0, AccHit=0, acc_valid=0, acc_tag=0, acc_q=0.
- Handshake:
  - InReady = !OutValid || OutReady, combinational.
  - Latency 1 cycle: a request accepted at edge N is presented from edge N on.
  - OutBus, Illegal and AccHit hold stable while OutValid && !OutReady.
  - OutValid clears when the result is taken and no new request is accepted that cycle.
- Modes, where hw = Imm26[22:21] and imm16 = Imm26[20:5]:
  - 000 I: zero-extend Imm26[21:10].
  - 001 D: sign-extend Imm26[20:12].
  - 010 B: sign-extend Imm26[25:0], then << BR_SHIFT if BrShift=1.
  - 011 CB: sign-extend Imm26[23:5], then << BR_SHIFT if BrShift=1.
  - 100 MOVZ: imm16 << (hw*16).
  - 101 MOVK: (src & ~(16'hFFFF << hw*16)) | (imm16 << hw*16).
    - src = acc_q when acc_valid && acc_tag==Rd; AccHit=1.
    - Otherwise src = Base; AccHit=0.
  - 110 MOVN: ~(imm16 << hw*16).
  - 111: OutBus=0, Illegal=1.
- Width rules:
  - All intermediate results are computed at DATA_W+BR_SHIFT bits and truncated to DATA_W.
  - For MOV modes, hw*16 >= DATA_W (hw>=2 when DATA_W=32) gives OutBus=0, Illegal=1, and no accumulator update.
- Accumulator, updated only on acceptance:
  - A legal MOVZ/MOVN/MOVK loads acc_q with the result, sets acc_tag=Rd and acc_valid=1.
  - Any other accepted mode leaves the accumulator unchanged.
  - Back-to-back MOVZ then MOVK to the same Rd forward correctly, because acc_q updates on the first acceptance edge.
- Flush:
  - Clears OutValid, Illegal, AccHit and acc_valid; OutBus is held.
  - Flush with InValid in the same cycle: the request is dropped, InReady is still driven normally, and the accumulator is not updated.
- Reset asserted mid-stall discards the held result immediately (async).

Decomposition:
- Shared package (decode_pkg) holds:
  - the Ctrl encodings: IMM_I, IMM_D, IMM_B, IMM_CB, IMM_MOVZ, IMM_MOVK, IMM_MOVN, IMM_ILL;
  - the HW_SHIFT_UNIT=16 constant.
- Sub-module imm_extract is purely combinational. It covers mode decode, extension, shift and MOVK merge, and outputs result plus illegal.
- imm_gen_pipe owns the handshake register and the accumulator.

Test Plan:
- DATA_W=64, Ctrl=001, Imm26[20:12]=9'h1F0, OutReady=1 -> one cycle later OutBus=64'hFFFF_FFFF_FFFF_FFF0, OutValid=1, Illegal=0.
- Ctrl=010, Imm26=26'h3FFFFFF, BrShift=1 -> OutBus=64'hFFFF_FFFF_FFFF_FFFC; same input with BrShift=0 -> 64'hFFFF_FFFF_FFFF_FFFF.
- Back-to-back requests to Rd=5:
  - MOVZ imm16=16'h1234, hw=3 -> OutBus=64'h1234_0000_0000_0000.
  - Next cycle, MOVK imm16=16'hBEEF, hw=0, Base=0 -> OutBus=64'h1234_0000_0000_BEEF, AccHit=1.
- MOVK to Rd=6 after the Rd=5 chain, Base=64'hFFFF_FFFF_FFFF_FFFF, hw=1, imm16=0 -> OutBus=64'hFFFF_FFFF_0000_FFFF, AccHit=0.
- Hold OutReady=0 for 3 cycles with a valid result -> InReady=0 and OutBus/OutValid stable; then OutReady=1 -> the result is consumed and the queued request is accepted the same edge.
- DATA_W=32:
  - MOVZ hw=2 -> Illegal=1, OutBus=0, and a following MOVK misses the accumulator.
  - Ctrl=111 -> Illegal=1.
  - Flush and Reset each asserted mid-stall -> OutValid=0 at the next edge (Flush) or immediately (Reset).
